bitty_fetch_unit: RTL and testbench

- Instruction sequencer that drives the bitty core's run/instruction/done interface from the initiator side.
- Fetches 16-bit words from a synchronous instruction memory, one per cycle of operation:
  - presents the word on instruction and pulses run;
  - waits for the core's done, then advances the program counter.
- Sits between the instruction ROM and the core at top level.
- Reports progress, completion and a done-timeout error.

---
 rtl/bitty_fetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_bitty_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit
// ----------------
// Instruction sequencer that drives the bitty core from the initiator side.
// It fetches one 16-bit word from a synchronous instruction memory and
// presents it on `instruction` with a one-cycle `run` pulse. It then waits
// for the core's `done` before advancing the program counter. It reports
// progress (instr_count), normal completion (finished) and a done-timeout
// (error).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   begin program at address 0 (accepted in IDLE only)
//   last_addr    in   address of final instruction, latched at start
//   mem_addr     out  instruction memory address (follows pc)
//   mem_rd       out  memory read strobe; mem_data valid next cycle
//   mem_data     in   memory read data
//   instruction  out  registered instruction word to the core
//   run          out  one-cycle pulse to the core
//   done         in   core completion pulse (only honoured in EXEC)
//   busy         out  high in any state other than IDLE
//   finished     out  sticky: program completed normally
//   error        out  sticky: core failed to answer within TIMEOUT cycles
//   pc           out  current program counter
//   instr_count  out  instructions completed since last start (saturating)
//
// Parameters:
//   ADDR_W   width of program counter and memory address
//   TIMEOUT  max cycles spent in EXEC waiting for done (>= 2)

module bitty_fetch_unit #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
    output logic [15:0]       instruction,
    output logic              run,
    input  logic              done,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count
);

    // The timer holds 0 in the first EXEC cycle. It only has to reach
    // TIMEOUT-2: when done is still low in that cycle, the TIMEOUT-th EXEC
    // cycle would follow, so the unit gives up at that edge instead.
    localparam int unsigned TW = (TIMEOUT < 4) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        EXEC
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       count_q, count_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              fin_q, fin_d;
    logic              err_q, err_d;

    logic              is_last;
    logic              timed_out;

    assign is_last   = (pc_q == last_q);
    assign timed_out = (timer_q == TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD:  state_d = ISSUE;
            ISSUE: state_d = EXEC;
            EXEC: begin
                if (done) begin
                    state_d = is_last ? IDLE : FETCH;
                end else if (timed_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            last_q  <= '0;
            instr_q <= '0;
            count_q <= '0;
            timer_q <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            last_q  <= last_d;
            instr_q <= instr_d;
            count_q <= count_d;
            timer_q <= timer_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        last_d  = last_q;
        instr_d = instr_q;
        count_d = count_q;
        timer_d = timer_q;
        fin_d   = fin_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    count_d = '0;
                    fin_d   = 1'b0;
                    err_d   = 1'b0;
                    last_d  = last_addr;
                end
            end
            LOAD: begin
                instr_d = mem_data;
            end
            ISSUE: begin
                timer_d = '0;
            end
            EXEC: begin
                timer_d = timer_q + TW'(1);
                if (done) begin
                    if (count_q != '1) begin
                        count_d = count_q + 16'd1;
                    end
                    // pc stops at the final address, so an all-ones last
                    // address never wraps back to zero.
                    if (is_last) begin
                        fin_d = 1'b1;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end else if (timed_out) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd = (state_q == FETCH);
        run    = (state_q == ISSUE);
        busy   = (state_q != IDLE);
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_count = count_q;
    assign finished    = fin_q;
    assign error       = err_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
module tb_bitty_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  last_addr = '0;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = '0;
    logic [15:0] instruction;
    logic        run;
    logic        done;
    logic        busy;
    logic        finished;
    logic        error;
    logic [7:0]  pc;
    logic [15:0] instr_count;

    int checks = 0;
    int failures = 0;

    logic [15:0] rom [0:255];
    logic        core_en = 1'b1;
    logic        stray_done = 1'b0;
    logic        core_done = 1'b0;
    logic [2:0]  core_cnt = '0;
    int          cyc = 0;
    int          run_double = 0;
    logic        prev_run = 1'b0;
    logic [15:0] run_log [$];
    int          run_cyc [$];
    logic [7:0]  addr_log [$];

    assign done = core_done | stray_done;

    bitty_fetch_unit #(
        .ADDR_W (8),
        .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .last_addr  (last_addr),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .instruction(instruction),
        .run        (run),
        .done       (done),
        .busy       (busy),
        .finished   (finished),
        .error      (error),
        .pc         (pc),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data appears the cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

    // Core model: done is high in the 4th cycle after the run cycle.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (reset) begin
            core_cnt <= '0;
        end else if (run && core_en) begin
            core_cnt <= 3'd3;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 3'd1;
            if (core_cnt == 3'd1) core_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            run_log.push_back(instruction);
            run_cyc.push_back(cyc);
        end
        if (mem_rd) addr_log.push_back(mem_addr);
        if (run && prev_run) run_double <= run_double + 1;
        prev_run <= run;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_run(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (run) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({busy, run, mem_rd, finished, error, pc, instruction, instr_count} !== '0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d got busy=%b run=%b rd=%b fin=%b err=%b pc=%h ins=%h cnt=%h exp all zero",
                         i, busy, run, mem_rd, finished, error, pc, instruction, instr_count);
            end
        end
    endtask

    task automatic test_program();
        int rb, ab, db, s;
        bit to;
        logic [15:0] exp_ins [3];
        exp_ins[0] = 16'h1234;
        exp_ins[1] = 16'h0041;
        exp_ins[2] = 16'hABCD;
        for (int i = 0; i < 3; i++) rom[i] = exp_ins[i];
        core_en = 1'b1;
        rb = run_log.size();
        ab = addr_log.size();
        db = run_double;
        last_addr = 8'd2;
        start = 1'b1;
        tick();
        s = cyc;
        start = 1'b0;
        wait_idle(100, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL prog_timeout got busy=%b exp busy=0 within 100 cycles", busy);
        end
        checks++;
        if (run_log.size() - rb != 3) begin
            failures++;
            $display("FAIL prog_runs got=%0d exp=3", run_log.size() - rb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (run_log[rb + i] !== exp_ins[i]) begin
                    failures++;
                    $display("FAIL prog_instr%0d got=%h exp=%h", i, run_log[rb + i], exp_ins[i]);
                end
            end
            // start high in cycle s-1; run three cycles later at edge s+2
            checks++;
            if (run_cyc[rb] - s != 2) begin
                failures++;
                $display("FAIL prog_first_run_latency got=%0d exp=2 edges after start edge", run_cyc[rb] - s);
            end
        end
        checks++;
        if (addr_log.size() - ab != 3) begin
            failures++;
            $display("FAIL prog_fetches got=%0d exp=3", addr_log.size() - ab);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (addr_log[ab + i] !== 8'(i)) begin
                    failures++;
                    $display("FAIL prog_addr%0d got=%h exp=%h", i, addr_log[ab + i], 8'(i));
                end
            end
        end
        checks++;
        if (run_double != db) begin
            failures++;
            $display("FAIL prog_run_width got=%0d wide pulses exp=0", run_double - db);
        end
        checks++;
        if ({finished, busy, error} !== 3'b100 || instr_count !== 16'd3 || pc !== 8'd2) begin
            failures++;
            $display("FAIL prog_end got fin=%b busy=%b err=%b cnt=%0d pc=%0d exp fin=1 busy=0 err=0 cnt=3 pc=2",
                     finished, busy, error, instr_count, pc);
        end
    endtask

    task automatic test_stray_done();
        bit to;
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        core_en = 1'b1;
        last_addr = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        stray_done = 1'b1;      // held through FETCH, LOAD and ISSUE
        tick();
        tick();
        checks++;
        if (run !== 1'b1) begin
            failures++;
            $display("FAIL stray_run got=%b exp=1", run);
        end
        tick();
        stray_done = 1'b0;
        tick();
        tick();
        checks++;
        if (pc !== 8'd0 || instr_count !== 16'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stray_ignored got pc=%0d cnt=%0d busy=%b exp pc=0 cnt=0 busy=1", pc, instr_count, busy);
        end
        wait_idle(100, to);
        checks++;
        if (to || finished !== 1'b1 || instr_count !== 16'd2 || pc !== 8'd1) begin
            failures++;
            $display("FAIL stray_end got to=%b fin=%b cnt=%0d pc=%0d exp to=0 fin=1 cnt=2 pc=1", to, finished, instr_count, pc);
        end
    endtask

    task automatic test_timeout();
        bit to;
        core_en = 1'b0;
        last_addr = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run(20, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL tmo_run got run=%b exp=1 within 20 cycles", run);
        end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_early got err=%b busy=%b exp err=0 busy=1 7 cycles after run", error, busy);
        end
        tick();
        checks++;
        if ({error, busy, finished} !== 3'b100 || pc !== 8'd0) begin
            failures++;
            $display("FAIL tmo_error got err=%b busy=%b fin=%b pc=%0d exp err=1 busy=0 fin=0 pc=0", error, busy, finished, pc);
        end
        core_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_restart_clear got err=%b busy=%b exp err=0 busy=1", error, busy);
        end
        wait_idle(100, to);
        checks++;
        if (to || {finished, error} !== 2'b10 || instr_count !== 16'd3) begin
            failures++;
            $display("FAIL tmo_rerun got to=%b fin=%b err=%b cnt=%0d exp to=0 fin=1 err=0 cnt=3", to, finished, error, instr_count);
        end
    endtask

    task automatic test_mid_reset();
        bit to, to2;
        int ab;
        core_en = 1'b1;
        last_addr = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run(20, to);
        wait_run(20, to2);
        checks++;
        if (to || to2 || pc !== 8'd1) begin
            failures++;
            $display("FAIL mrst_second_run got to=%b pc=%0d exp to=0 pc=1", to | to2, pc);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, run, mem_rd, finished, error, pc, mem_addr, instruction, instr_count} !== '0) begin
            failures++;
            $display("FAIL mrst_values got busy=%b run=%b rd=%b fin=%b err=%b pc=%h addr=%h ins=%h cnt=%h exp all zero",
                     busy, run, mem_rd, finished, error, pc, mem_addr, instruction, instr_count);
        end
        ab = addr_log.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(100, to);
        checks++;
        if (to || addr_log.size() <= ab || addr_log[ab] !== 8'd0 || instr_count !== 16'd3) begin
            failures++;
            $display("FAIL mrst_restart got to=%b first_addr=%h cnt=%0d exp to=0 first_addr=00 cnt=3",
                     to, (addr_log.size() > ab) ? addr_log[ab] : 8'hxx, instr_count);
        end
    endtask

    task automatic test_single();
        bit to;
        int rb;
        rom[0] = 16'h5A5A;
        core_en = 1'b1;
        last_addr = 8'd0;
        for (int pass = 0; pass < 2; pass++) begin
            rb = run_log.size();
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (finished !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL single%0d_start got fin=%b busy=%b exp fin=0 busy=1", pass, finished, busy);
            end
            wait_idle(100, to);
            checks++;
            if (to || run_log.size() - rb != 1 || finished !== 1'b1 || instr_count !== 16'd1 || pc !== 8'd0) begin
                failures++;
                $display("FAIL single%0d_end got to=%b runs=%0d fin=%b cnt=%0d pc=%0d exp to=0 runs=1 fin=1 cnt=1 pc=0",
                         pass, to, run_log.size() - rb, finished, instr_count, pc);
            end else begin
                checks++;
                if (run_log[rb] !== 16'h5A5A) begin
                    failures++;
                    $display("FAIL single%0d_instr got=%h exp=5a5a", pass, run_log[rb]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'(i * 3 + 7);
        test_reset();
        test_program();
        test_stray_done();
        test_timeout();
        test_mid_reset();
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
